pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates enables and flushes for load-use stalls, branch/jump redirects, multi-cycle data-memory waits and the post-reset fill.
- Consumes decode-stage source registers and the EX-stage control bits produced by the control unit (reg write, mem read, branch/jump result).

Parameters:
RESET_HOLD, 2, cycles after reset release during which PC is held and all pipeline registers are flushed
MEM_TIMEOUT, 64, MEM_WAIT cycles without ack before mem_timeout_err asserts
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of instruction in EX
ex_mem_read  in  1  EX instruction is a load (mem_do_read_ctrl)
ex_redirect  in  1  EX branch taken or jump (PC change)
dmem_req  in  1  MEM stage issuing a data access this cycle
dmem_ack  in  1  data memory completes access this cycle
pc_en  out  1  PC may update
if_id_en  out  1  IF/ID register load
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX register load
id_ex_flush  out  1  ID/EX loads NOP bubble
ex_mem_en  out  1  EX/MEM register load
mem_wb_en  out  1  MEM/WB register load
mem_wb_bubble  out  1  MEM/WB loads NOP bubble
mem_timeout_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states (shared enum): ST_HOLD=0, ST_RUN=1, ST_MEMWAIT=2.
- Reset: state=ST_HOLD, hold counter=0, wait counter=0, mem_timeout_err=0. While rst=1 outputs follow ST_HOLD rules. Reset mid-MEMWAIT abandons the wait and returns to ST_HOLD.
- ST_HOLD: pc_en=0, all *_en=1, if_id_flush=id_ex_flush=mem_wb_bubble=1. Count RESET_HOLD cycles, then go to ST_RUN. RESET_HOLD=0 means ST_RUN on the first cycle after reset.
- Outputs are combinational from state and inputs. Priority in ST_RUN, highest first:
  1. Memory stall: dmem_req && !dmem_ack. pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_en=1, mem_wb_bubble=1. Next state ST_MEMWAIT, wait counter=1.
  2. Redirect: ex_redirect=1. All en=1, if_id_flush=1, id_ex_flush=1. Supersedes load-use in the same cycle.
  3. Load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). pc_en=0, if_id_en=0, id_ex_flush=1, other en=1. Lasts exactly one cycle: the load leaves EX next cycle.
  4. Otherwise all en=1, no flush or bubble.
- dmem_req && dmem_ack in the same cycle: zero-wait access, no stall.
- ST_MEMWAIT: freeze as in rule 1 while !dmem_ack. Wait counter increments and saturates. When it reaches MEM_TIMEOUT, set mem_timeout_err (sticky until rst); the wait continues.
- ST_MEMWAIT with dmem_ack: the release cycle applies ST_RUN rules 2–4 with dmem stall ignored, then go to ST_RUN. A redirect held in the frozen EX stage takes effect on this release cycle.
- ex_rd=0 never causes a load-use stall.

Optional Feature:
- Macro PIPE_PERF_CNT_EN defined: adds outputs stall_cycles, flush_events, memwait_cycles (each CNT_W bits, wrapping).
  - stall_cycles counts cycles with pc_en=0 in ST_RUN/ST_MEMWAIT.
  - flush_events counts redirect cycles.
  - memwait_cycles counts cycles spent in ST_MEMWAIT.
  - All counters clear on rst.
- Macro undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum hz_state_t, the REG_ZERO constant (5'd0), and a packed struct pipe_ctl_t bundling the en/flush outputs.
- One natural sub-module: hazard_detect, purely combinational load-use compare (rule 3). The FSM and counters stay in the top module.

Test Plan:
- Reset then release, RESET_HOLD=2 → pc_en=0 and flushes=1 for 2 cycles after release, then ST_RUN with all en=1.
- ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd=0 → no stall.
- Load-use condition and ex_redirect=1 together → if_id_flush=id_ex_flush=1, pc_en=1.
- dmem_req=1, ack after 3 cycles → 3 frozen cycles with mem_wb_bubble=1, release on ack cycle. dmem_req=ack=1 → no stall.
- ex_redirect=1 held during a 2-cycle memory wait → flushes appear only on the ack cycle.
- MEM_TIMEOUT=4, ack never arrives → mem_timeout_err rises on the 4th wait cycle, stays set after ack, clears on rst. Assert rst mid-wait → ST_HOLD next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// the architectural zero register and the bundle of pipeline-register
// enable/flush controls, plus constructors for the fixed control patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } pipe_ctl_t;

  // Post-reset fill: PC frozen, every stage loads a NOP.
  function automatic pipe_ctl_t ctl_hold();
    pipe_ctl_t c;
    c.pc_en         = 1'b0;
    c.if_id_en      = 1'b1;
    c.if_id_flush   = 1'b1;
    c.id_ex_en      = 1'b1;
    c.id_ex_flush   = 1'b1;
    c.ex_mem_en     = 1'b1;
    c.mem_wb_en     = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

  // Free-running pipeline: everything advances, nothing is squashed.
  function automatic pipe_ctl_t ctl_run();
    pipe_ctl_t c;
    c.pc_en         = 1'b1;
    c.if_id_en      = 1'b1;
    c.if_id_flush   = 1'b0;
    c.id_ex_en      = 1'b1;
    c.id_ex_flush   = 1'b0;
    c.ex_mem_en     = 1'b1;
    c.mem_wb_en     = 1'b1;
    c.mem_wb_bubble = 1'b0;
    return c;
  endfunction

  // Data-memory wait: front end and MEM frozen, WB drains a bubble so the
  // pending access is not retired twice.
  function automatic pipe_ctl_t ctl_freeze();
    pipe_ctl_t c;
    c.pc_en         = 1'b0;
    c.if_id_en      = 1'b0;
    c.if_id_flush   = 1'b0;
    c.id_ex_en      = 1'b0;
    c.id_ex_flush   = 1'b0;
    c.ex_mem_en     = 1'b0;
    c.mem_wb_en     = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

  // Taken branch / jump: squash the two younger instructions.
  function automatic pipe_ctl_t ctl_redirect();
    pipe_ctl_t c;
    c = ctl_run();
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  function automatic pipe_ctl_t ctl_load_use();
    pipe_ctl_t c;
    c = ctl_run();
    c.pc_en       = 1'b0;
    c.if_id_en    = 1'b0;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source the
// ID instruction actually reads. Writes to x0 never create a hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Compare each used source against the load destination.
  always_comb begin
    rs1_hit_s  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit_s  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) && (rs1_hit_s || rs2_hit_s);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC and the IF/ID, ID/EX, EX/MEM,
// MEM/WB registers through post-reset fill, load-use stalls, redirects and
// data-memory waits. Outputs are combinational from state and inputs.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_redirect,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       mem_wb_bubble,
  output logic       mem_timeout_err,
  output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] memwait_cycles
`endif
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (RESET_HOLD > 1) ? HOLD_W'(RESET_HOLD - 1) : '0;
  // With no fill period the pipeline must already be running on the first
  // cycle after reset; rst itself still forces the fill controls.
  localparam hz_state_t RESET_STATE = (RESET_HOLD == 0) ? ST_RUN : ST_HOLD;

  hz_state_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;

  pipe_ctl_t ctl_s;
  pipe_ctl_t flow_ctl_s;
  logic      load_use_s;
  logic      mem_stall_s;
  logic      hold_last_s;
  logic      redirect_fire_s;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_rd_i       (ex_rd),
    .ex_mem_read_i (ex_mem_read),
    .load_use_o    (load_use_s)
  );

  // Non-memory hazard resolution: redirect beats load-use beats free run.
  always_comb begin
    flow_ctl_s = ctl_run();
    if (ex_redirect) begin
      flow_ctl_s = ctl_redirect();
    end else if (load_use_s) begin
      flow_ctl_s = ctl_load_use();
    end else begin
      flow_ctl_s = ctl_run();
    end
  end

  // Condition terms used by the FSM.
  always_comb begin
    mem_stall_s = dmem_req && !dmem_ack;
    hold_last_s = (RESET_HOLD <= 1) || (hold_cnt_q == HOLD_LAST);
  end

  // Next-state, counters and pipeline controls.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    err_d           = err_q;
    ctl_s           = ctl_hold();
    redirect_fire_s = 1'b0;
    if (rst) begin
      ctl_s = ctl_hold();
    end else begin
      case (state_q)
        ST_HOLD: begin
          ctl_s = ctl_hold();
          if (hold_last_s) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (mem_stall_s) begin
            ctl_s      = ctl_freeze();
            state_d    = ST_MEMWAIT;
            wait_cnt_d = WAIT_W'(1);
          end else begin
            ctl_s           = flow_ctl_s;
            redirect_fire_s = ex_redirect;
          end
        end
        ST_MEMWAIT: begin
          if (!dmem_ack) begin
            ctl_s = ctl_freeze();
            if (wait_cnt_q != WAIT_MAX) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else begin
              wait_cnt_d = wait_cnt_q;
            end
          end else begin
            // Release cycle: the stage contents frozen in EX act now.
            ctl_s           = flow_ctl_s;
            redirect_fire_s = ex_redirect;
            state_d         = ST_RUN;
            wait_cnt_d      = '0;
          end
        end
        default: begin
          ctl_s      = ctl_hold();
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          wait_cnt_d = '0;
        end
      endcase
      if ((state_d == ST_MEMWAIT) && (wait_cnt_d == WAIT_MAX)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State, fill/wait counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Drive the individual pipeline controls and debug state.
  always_comb begin
    pc_en           = ctl_s.pc_en;
    if_id_en        = ctl_s.if_id_en;
    if_id_flush     = ctl_s.if_id_flush;
    id_ex_en        = ctl_s.id_ex_en;
    id_ex_flush     = ctl_s.id_ex_flush;
    ex_mem_en       = ctl_s.ex_mem_en;
    mem_wb_en       = ctl_s.mem_wb_en;
    mem_wb_bubble   = ctl_s.mem_wb_bubble;
    mem_timeout_err = err_q;
    if (rst) begin
      state_o = ST_HOLD;
    end else begin
      state_o = state_q;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, memwait_cnt_d;

  // Increment terms for the wrapping performance counters.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (!rst && (state_q != ST_HOLD) && !ctl_s.pc_en) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_fire_s) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (!rst && (state_q == ST_MEMWAIT)) begin
      memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
    end else begin
      memwait_cnt_d = memwait_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign flush_events   = flush_cnt_q;
  assign memwait_cycles = memwait_cnt_q;
`endif

endmodule
